a2d_intf: RTL

Round-robin front end for the external 8-channel 12-bit SPI A/D converter. It issues command words to the SPI master and consumes its `done`/`rd_data` results. Every timer period it converts one of four channels (battery, current, brake, torque) and holds each latest 12-bit result in a dedicated output register for the motor-control and assist logic.

---
 rtl/a2d_intf.sv | 136 +++++++++++++
 1 files changed

// File: rtl/a2d_intf.sv
`timescale 1ns/1ps
// Round-robin SPI A/D front end: every 2^PERIOD_W clocks it runs one two-transaction
// conversion on the next of four channels and holds each latest 12-bit result.
module a2d_intf #(
    parameter int PERIOD_W = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        cnv_cmplt
);

    typedef enum logic [2:0] {IDLE, XFER1, GAP, XFER2, CAPT} state_t;

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   tmr_q, tmr_d;
    logic [1:0]            robin_q, robin_d;
    logic                  done_ff_q;
    logic                  wrt_q, wrt_d;
    logic [15:0]           cmd_q, cmd_d;
    logic [11:0]           batt_q, batt_d, curr_q, curr_d;
    logic [11:0]           brake_q, brake_d, torque_q, torque_d;
    logic                  cnv_cmplt_q, cnv_cmplt_d;
    logic                  tmr_full_nxt;
    logic                  xfer_cmplt;
    logic [2:0]            chnl;
    logic                  unused_rd_hi;

    // The ADC result field is 12 bits; the top nibble of the SPI word carries nothing.
    assign unused_rd_hi = ^rd_data[15:12];

    assign tmr_d      = tmr_q + PERIOD_W'(1);
    // wrt is registered, so it is launched one clock early to be high while tmr is all-ones.
    assign tmr_full_nxt = &tmr_d;
    assign xfer_cmplt = done & ~done_ff_q;

    always_comb begin
        case (robin_q)
            2'd0:    chnl = 3'd0;
            2'd1:    chnl = 3'd1;
            2'd2:    chnl = 3'd3;
            default: chnl = 3'd4;
        endcase
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        robin_d     = robin_q;
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        batt_d      = batt_q;
        curr_d      = curr_q;
        brake_d     = brake_q;
        torque_d    = torque_q;
        cnv_cmplt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tmr_full_nxt) begin
                    wrt_d   = 1'b1;
                    cmd_d   = {2'b00, chnl, 11'h000};
                    state_d = XFER1;
                end
            end
            XFER1: begin
                if (xfer_cmplt) state_d = GAP;
            end
            GAP: begin
                wrt_d   = 1'b1;
                state_d = XFER2;
            end
            XFER2: begin
                if (xfer_cmplt) begin
                    state_d     = CAPT;
                    cnv_cmplt_d = 1'b1;
                    case (robin_q)
                        2'd0:    batt_d   = rd_data[11:0];
                        2'd1:    curr_d   = rd_data[11:0];
                        2'd2:    brake_d  = rd_data[11:0];
                        default: torque_d = rd_data[11:0];
                    endcase
                end
            end
            CAPT: begin
                robin_d = robin_q + 2'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            robin_q     <= 2'd0;
            done_ff_q   <= 1'b1;
            wrt_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            batt_q      <= 12'h000;
            curr_q      <= 12'h000;
            brake_q     <= 12'h000;
            torque_q    <= 12'h000;
            cnv_cmplt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            robin_q     <= robin_d;
            done_ff_q   <= done;
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            batt_q      <= batt_d;
            curr_q      <= curr_d;
            brake_q     <= brake_d;
            torque_q    <= torque_d;
            cnv_cmplt_q <= cnv_cmplt_d;
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign batt      = batt_q;
    assign curr      = curr_q;
    assign brake     = brake_q;
    assign torque    = torque_q;
    assign cnv_cmplt = cnv_cmplt_q;

endmodule
